// File: rtl/bus_frontend_pkg.sv
// Shared definitions for the MCU bus front end: read FSM states, register map
// constants and status byte layout.
package bus_frontend_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RD_WAIT = 2'd1,
    ST_RD_HOLD = 2'd2
  } rd_state_e;

  localparam logic [7:0] ADDR_STATUS   = 8'h12;
  localparam logic [7:0] ADDR_WIN_BASE = 8'h10;

  localparam int STAT_FULL_BIT = 4;
  localparam int STAT_OVF_BIT  = 5;
  localparam int STAT_TMO_BIT  = 6;

endpackage

// File: rtl/cmd_fifo.sv
// First-word-fall-through command FIFO; a push on a full FIFO is accepted only
// when a pop happens in the same cycle.
module cmd_fifo #(
  parameter  int DEPTH = 4,
  parameter  int WIDTH = 16,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             valid_o,
  output logic             full_o,
  output logic [CW-1:0]    count_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    count_q;
  logic             push_ok, pop_ok;

  assign valid_o = (count_q != '0);
  assign full_o  = (count_q == CW'(DEPTH));
  assign pop_ok  = pop_i && valid_o;
  assign push_ok = push_i && (!full_o || pop_ok);
  assign rdata_o = mem_q[rd_ptr_q];
  assign count_o = count_q;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_q + CW'(push_ok) - CW'(pop_ok);
    end
  end

  // NOTE: storage is deliberately not reset; the pointers and count define
  // which entries are meaningful, and an unreset array maps onto plain RAM.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/bus_frontend.sv
// MCU bus front end: synchronizes async strobes, queues windowed writes into a
// command FIFO and serves reads from the status register or downstream.
module bus_frontend
  import bus_frontend_pkg::*;
#(
  parameter int FIFO_DEPTH  = 4,
  parameter int SYNC_STAGES = 2,
  parameter int RD_TIMEOUT  = 8
) (
  input  logic       osc,
  input  logic       rst,
  input  logic       ale,
  input  logic       write,
  input  logic       read,
  input  logic [7:0] data_in,
  output logic [7:0] data_out,
  output logic       data_oe,
  output logic       cmd_valid,
  input  logic       cmd_ready,
  output logic [7:0] cmd_addr,
  output logic [7:0] cmd_data,
  output logic       rd_req,
  output logic [7:0] rd_addr,
  input  logic       rd_valid,
  input  logic [7:0] rd_data
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int TW = $clog2(RD_TIMEOUT + 1);

  // Strobe order in the vectors below: [0] ale, [1] write, [2] read.
  logic [2:0] strobe_raw, strobe_s, strobe_prev_q;
  assign strobe_raw = {read, write, ale};

  for (genvar g = 0; g < 3; g++) begin : g_sync
    logic [SYNC_STAGES-1:0] sync_q;
    always_ff @(posedge osc) begin
      if (rst) sync_q <= '1;
      else     sync_q <= {sync_q[SYNC_STAGES-2:0], strobe_raw[g]};
    end
    assign strobe_s[g] = sync_q[SYNC_STAGES-1];
  end

  always_ff @(posedge osc) begin
    if (rst) strobe_prev_q <= '1;
    else     strobe_prev_q <= strobe_s;
  end

  logic ale_fall, wr_rise, rd_fall, rd_rise;
  assign ale_fall = strobe_prev_q[0] & ~strobe_s[0];
  assign wr_rise  = ~strobe_prev_q[1] & strobe_s[1];
  assign rd_fall  = strobe_prev_q[2] & ~strobe_s[2];
  assign rd_rise  = ~strobe_prev_q[2] & strobe_s[2];

  logic [7:0] addr_q;
  logic       ovf_q, tmo_q;
  logic       push_req, pop, sticky_clr, ovf_set, tmo_set;
  logic       fifo_full;
  logic [CW-1:0] fifo_count;

  assign pop        = cmd_valid && cmd_ready;
  assign push_req   = wr_rise && (addr_q[7:4] == ADDR_WIN_BASE[7:4]) && (addr_q != ADDR_STATUS);
  assign sticky_clr = wr_rise && (addr_q == ADDR_STATUS) && data_in[0];
  assign ovf_set    = push_req && fifo_full && !pop;

  cmd_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(16)) u_cmd_fifo (
    .clk     (osc),
    .rst     (rst),
    .push_i  (push_req),
    .wdata_i ({addr_q, data_in}),
    .pop_i   (pop),
    .rdata_o ({cmd_addr, cmd_data}),
    .valid_o (cmd_valid),
    .full_o  (fifo_full),
    .count_o (fifo_count)
  );

  logic [7:0] status;
  always_comb begin
    status                = '0;
    status[3:0]           = 4'(fifo_count);
    status[STAT_FULL_BIT] = fifo_full;
    status[STAT_OVF_BIT]  = ovf_q;
    status[STAT_TMO_BIT]  = tmo_q;
  end

  rd_state_e     state_q, state_d;
  logic [7:0]    data_out_q, data_out_d, rd_addr_q, rd_addr_d;
  logic          rd_req_q, rd_req_d;
  logic [TW-1:0] tmo_cnt_q, tmo_cnt_d;

  // NOTE: every output of this block is given a default first so no path
  // leaves a signal unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d    = state_q;
    data_out_d = data_out_q;
    rd_addr_d  = rd_addr_q;
    rd_req_d   = 1'b0;
    tmo_cnt_d  = tmo_cnt_q;
    tmo_set    = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (rd_fall) begin
          if (addr_q == ADDR_STATUS) begin
            data_out_d = status;
            state_d    = ST_RD_HOLD;
          end else if (addr_q[4]) begin
            rd_req_d  = 1'b1;
            rd_addr_d = addr_q;
            tmo_cnt_d = '0;
            state_d   = ST_RD_WAIT;
          end
        end
      end
      ST_RD_WAIT: begin
        if (rd_rise) begin
          state_d = ST_IDLE;
        end else if (rd_valid) begin
          data_out_d = rd_data;
          state_d    = ST_RD_HOLD;
        end else if (tmo_cnt_q == TW'(RD_TIMEOUT - 1)) begin
          data_out_d = 8'hFF;
          tmo_set    = 1'b1;
          state_d    = ST_RD_HOLD;
        end else begin
          tmo_cnt_d = tmo_cnt_q + TW'(1);
        end
      end
      ST_RD_HOLD: if (rd_rise) state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge osc) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      data_out_q <= '0;
      rd_addr_q  <= '0;
      rd_req_q   <= 1'b0;
      tmo_cnt_q  <= '0;
      addr_q     <= '0;
      ovf_q      <= 1'b0;
      tmo_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      data_out_q <= data_out_d;
      rd_addr_q  <= rd_addr_d;
      rd_req_q   <= rd_req_d;
      tmo_cnt_q  <= tmo_cnt_d;
      if (ale_fall) addr_q <= data_in;
      // A clear wins over a set landing in the same cycle.
      if (sticky_clr)   ovf_q <= 1'b0;
      else if (ovf_set) ovf_q <= 1'b1;
      if (sticky_clr)   tmo_q <= 1'b0;
      else if (tmo_set) tmo_q <= 1'b1;
    end
  end

  assign data_out = data_out_q;
  assign rd_req   = rd_req_q;
  assign rd_addr  = rd_addr_q;
  assign data_oe  = !read && addr_q[4];

endmodule

// File: tb/tb_bus_frontend.sv
// Self-checking bench for bus_frontend against a queue-based model of the
// MCU-visible register map and command FIFO.
module tb_bus_frontend;

  localparam int FIFO_DEPTH  = 4;
  localparam int SYNC_STAGES = 2;
  localparam int RD_TIMEOUT  = 8;
  localparam int SETTLE      = SYNC_STAGES + 4;

  logic       osc = 1'b0;
  logic       rst, ale, write, read, cmd_ready, rd_valid;
  logic [7:0] data_in, rd_data;
  logic [7:0] data_out, cmd_addr, cmd_data, rd_addr;
  logic       data_oe, cmd_valid, rd_req;

  bus_frontend #(
    .FIFO_DEPTH (FIFO_DEPTH),
    .SYNC_STAGES(SYNC_STAGES),
    .RD_TIMEOUT (RD_TIMEOUT)
  ) dut (
    .osc       (osc),
    .rst       (rst),
    .ale       (ale),
    .write     (write),
    .read      (read),
    .data_in   (data_in),
    .data_out  (data_out),
    .data_oe   (data_oe),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_addr  (cmd_addr),
    .cmd_data  (cmd_data),
    .rd_req    (rd_req),
    .rd_addr   (rd_addr),
    .rd_valid  (rd_valid),
    .rd_data   (rd_data)
  );

  always #5 osc = ~osc;

  int checks = 0;
  int errors = 0;

  // Model of what the MCU and downstream side can observe.
  logic [15:0] m_q[$];
  bit          m_ovf, m_tmo;
  logic [7:0]  m_addr, m_dout;

  function automatic logic [7:0] m_status();
    return {1'b0, m_tmo, m_ovf, (m_q.size() == FIFO_DEPTH), 4'(m_q.size())};
  endfunction

  task automatic model_reset();
    m_q.delete();
    m_ovf  = 0;
    m_tmo  = 0;
    m_addr = 8'h00;
    m_dout = 8'h00;
  endtask

  task automatic model_write(input logic [7:0] d);
    if (m_addr == 8'h12) begin
      if (d[0]) begin
        m_ovf = 0;
        m_tmo = 0;
      end
    end else if (m_addr >= 8'h10 && m_addr <= 8'h1F) begin
      if (m_q.size() == FIFO_DEPTH) m_ovf = 1;
      else m_q.push_back({m_addr, d});
    end
  endtask

  task automatic settle();
    repeat (SETTLE) @(negedge osc);
  endtask

  task automatic mcu_addr(input logic [7:0] a);
    @(negedge osc);
    data_in = a;
    ale = 1'b0;
    settle();
    ale = 1'b1;
    settle();
    m_addr = a;
  endtask

  task automatic mcu_write(input logic [7:0] d);
    @(negedge osc);
    data_in = d;
    write = 1'b0;
    settle();
    write = 1'b1;
    settle();
    model_write(d);
  endtask

  task automatic read_status(input string name);
    logic [7:0] exp;
    mcu_addr(8'h12);
    exp = m_status();
    @(negedge osc);
    read = 1'b0;
    settle();
    checks++;
    if ({data_oe, data_out} !== {1'b1, exp}) begin
      errors++;
      $display("FAIL %s: got oe=%0b data=%02h expected oe=1 data=%02h", name, data_oe, data_out, exp);
    end
    read = 1'b1;
    settle();
    m_dout = exp;
  endtask

  task automatic pop_check(input string name);
    @(negedge osc);
    checks++;
    if (cmd_valid !== 1'b1 || {cmd_addr, cmd_data} !== m_q[0]) begin
      errors++;
      $display("FAIL %s: got valid=%0b entry=%04h expected valid=1 entry=%04h",
               name, cmd_valid, {cmd_addr, cmd_data}, m_q[0]);
    end
    cmd_ready = 1'b1;
    @(posedge osc);
    #1 cmd_ready = 1'b0;
    void'(m_q.pop_front());
  endtask

  task automatic wait_rd_req(input string name);
    int n = 0;
    while (rd_req !== 1'b1 && n < 12) begin
      @(negedge osc);
      n++;
    end
    checks++;
    if (rd_req !== 1'b1 || rd_addr !== m_addr) begin
      errors++;
      $display("FAIL %s: got rd_req=%0b rd_addr=%02h expected rd_req=1 rd_addr=%02h",
               name, rd_req, rd_addr, m_addr);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge osc);
    @(negedge osc);
    model_reset();
    checks++;
    if ({cmd_valid, rd_req, data_oe, data_out} !== {3'b000, 8'h00}) begin
      errors++;
      $display("FAIL reset_outputs: got valid=%0b rd_req=%0b oe=%0b data=%02h expected all zero",
               cmd_valid, rd_req, data_oe, data_out);
    end
    rst = 1'b0;
    settle();
    checks++;
    if (cmd_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_no_push: got cmd_valid=%0b expected 0", cmd_valid);
    end
    read_status("reset_status");
  endtask

  task automatic test_single_beat();
    int beats = 0;
    logic [15:0] got = '0;
    mcu_addr(8'h10);
    @(negedge osc);
    data_in = 8'hA5;
    write = 1'b0;
    settle();
    cmd_ready = 1'b1;
    write = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge osc);
      if (cmd_valid === 1'b1) begin
        beats++;
        got = {cmd_addr, cmd_data};
      end
    end
    cmd_ready = 1'b0;
    checks++;
    if (beats != 1 || got !== 16'h10A5) begin
      errors++;
      $display("FAIL single_beat: got beats=%0d entry=%04h expected beats=1 entry=10a5", beats, got);
    end
  endtask

  task automatic test_overflow();
    mcu_addr(8'h10);
    for (int i = 1; i <= 5; i++) mcu_write(8'(i));
    read_status("overflow_status");
    for (int i = 0; i < FIFO_DEPTH; i++) pop_check("overflow_pop");
    @(negedge osc);
    checks++;
    if (cmd_valid !== 1'b0) begin
      errors++;
      $display("FAIL overflow_drained: got cmd_valid=%0b expected 0", cmd_valid);
    end
    mcu_addr(8'h12);
    mcu_write(8'h01);
    read_status("overflow_cleared");
  endtask

  task automatic test_downstream_read();
    mcu_addr(8'h14);
    @(negedge osc);
    read = 1'b0;
    wait_rd_req("dsread_req");
    @(negedge osc);
    checks++;
    if (rd_req !== 1'b0) begin
      errors++;
      $display("FAIL dsread_pulse_width: got rd_req=%0b expected 0", rd_req);
    end
    @(negedge osc);
    @(negedge osc);
    rd_valid = 1'b1;
    rd_data  = 8'h5A;
    @(negedge osc);
    rd_valid = 1'b0;
    rd_data  = 8'($urandom);
    @(negedge osc);
    checks++;
    if ({data_oe, data_out, rd_addr} !== {1'b1, 8'h5A, 8'h14}) begin
      errors++;
      $display("FAIL dsread_data: got oe=%0b data=%02h rd_addr=%02h expected oe=1 data=5a rd_addr=14",
               data_oe, data_out, rd_addr);
    end
    read = 1'b1;
    settle();
    m_dout = 8'h5A;
    checks++;
    if ({data_oe, data_out} !== {1'b0, m_dout}) begin
      errors++;
      $display("FAIL dsread_release: got oe=%0b data=%02h expected oe=0 data=%02h", data_oe, data_out, m_dout);
    end
  endtask

  task automatic test_timeout();
    mcu_addr(8'h15);
    @(negedge osc);
    read = 1'b0;
    wait_rd_req("timeout_req");
    repeat (RD_TIMEOUT - 1) @(negedge osc);
    checks++;
    if (data_out !== m_dout) begin
      errors++;
      $display("FAIL timeout_early: got data=%02h expected %02h", data_out, m_dout);
    end
    @(negedge osc);
    m_dout = 8'hFF;
    m_tmo  = 1;
    checks++;
    if (data_out !== m_dout) begin
      errors++;
      $display("FAIL timeout_data: got data=%02h expected %02h", data_out, m_dout);
    end
    read = 1'b1;
    settle();
    read_status("timeout_status");
    mcu_write(8'h01);
    read_status("timeout_cleared");
  endtask

  task automatic test_abort();
    mcu_addr(8'h16);
    @(negedge osc);
    read = 1'b0;
    wait_rd_req("abort_req");
    read = 1'b1;
    settle();
    rd_valid = 1'b1;
    rd_data  = 8'h77;
    @(negedge osc);
    rd_valid = 1'b0;
    @(negedge osc);
    checks++;
    if (data_out !== m_dout) begin
      errors++;
      $display("FAIL abort_late_valid: got data=%02h expected %02h", data_out, m_dout);
    end
    read_status("abort_status");
  endtask

  task automatic test_reset_midflight();
    mcu_addr(8'h10);
    mcu_write(8'h11);
    mcu_write(8'h22);
    mcu_addr(8'h15);
    @(negedge osc);
    read = 1'b0;
    wait_rd_req("midrst_req");
    @(negedge osc);
    rst = 1'b1;
    @(negedge osc);
    checks++;
    if ({cmd_valid, rd_req, data_oe, data_out} !== {3'b000, 8'h00}) begin
      errors++;
      $display("FAIL midrst_outputs: got valid=%0b rd_req=%0b oe=%0b data=%02h expected all zero",
               cmd_valid, rd_req, data_oe, data_out);
    end
    read = 1'b1;
    @(negedge osc);
    rst = 1'b0;
    model_reset();
    settle();
    checks++;
    if ({cmd_valid, data_out} !== {1'b0, m_dout}) begin
      errors++;
      $display("FAIL midrst_after: got valid=%0b data=%02h expected valid=0 data=%02h",
               cmd_valid, data_out, m_dout);
    end
    read_status("midrst_status");
  endtask

  task automatic test_push_pop_full();
    mcu_addr(8'h10);
    for (int i = 0; i < FIFO_DEPTH; i++) mcu_write(8'hB1 + 8'(i));
    @(negedge osc);
    data_in = 8'hC5;
    write = 1'b0;
    settle();
    write = 1'b1;
    repeat (SYNC_STAGES) @(negedge osc);
    checks++;
    if ({cmd_valid, cmd_addr, cmd_data} !== {1'b1, m_q[0]}) begin
      errors++;
      $display("FAIL pushpop_head: got valid=%0b entry=%04h expected valid=1 entry=%04h",
               cmd_valid, {cmd_addr, cmd_data}, m_q[0]);
    end
    cmd_ready = 1'b1;
    @(negedge osc);
    cmd_ready = 1'b0;
    settle();
    void'(m_q.pop_front());
    m_q.push_back({8'h10, 8'hC5});
    read_status("pushpop_status");
    while (m_q.size() > 0) pop_check("pushpop_order");
  endtask

  task automatic test_random();
    logic [7:0] a, d;
    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 3))
        0: begin
          a = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h10 + 8'($urandom_range(0, 15));
          d = 8'($urandom);
          mcu_addr(a);
          mcu_write(d);
        end
        1: begin
          if (m_q.size() > 0) begin
            pop_check("random_pop");
          end else begin
            @(negedge osc);
            checks++;
            if (cmd_valid !== 1'b0) begin
              errors++;
              $display("FAIL random_empty: got cmd_valid=%0b expected 0", cmd_valid);
            end
          end
        end
        2: read_status("random_status");
        default: begin
          mcu_addr(8'h12);
          mcu_write(8'($urandom));
        end
      endcase
    end
    read_status("random_final");
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time budget");
    $fatal(1, "watchdog");
  end

  initial begin
    ale = 1'b1;
    write = 1'b1;
    read = 1'b1;
    cmd_ready = 1'b0;
    rd_valid = 1'b0;
    data_in = 8'h00;
    rd_data = 8'h00;
    rst = 1'b1;
    model_reset();
    test_reset();
    test_single_beat();
    test_overflow();
    test_downstream_read();
    test_timeout();
    test_abort();
    test_reset_midflight();
    test_push_pop_full();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
